// File: rtl/viterbi_frame_controller.sv
// Frame sequencer for the 64-state Viterbi decoder: packs coded bit pairs, strobes ACS steps,
// searches the best end state and launches traceback. Define VITERBI_ZERO_TAIL_EN to skip the search.
module viterbi_frame_controller #(
  parameter int MAX_LENGTH = 192,
  parameter int STATES     = 64,
  parameter int COST_W     = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        Length,
  input  logic              InValid,
  input  logic              Input,
  output logic              InReady,
  output logic              Clear,
  output logic              AcsStart,
  output logic [1:0]        Pair,
  input  logic              AcsDone,
  output logic [7:0]        Step,
  output logic [5:0]        CostAddr,
  input  logic [COST_W-1:0] CostData,
  output logic              TbStart,
  output logic [5:0]        TbState,
  output logic [7:0]        TbLength,
  input  logic              TbDone,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LENGTH);
  localparam logic [5:0] LAST_IDX  = 6'(STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_COLLECT, S_ACS, S_SCAN, S_TB, S_FIN
  } state_t;

  state_t      state, state_n;
  logic        first_r;
  logic        half_r;
  logic [7:0]  len_r;
  logic [7:0]  step_r;
  logic [1:0]  pair_r;
  logic [5:0]  tb_state_r;
  logic [7:0]  tb_len_r;
  logic        error_r;

  logic        start_req;
  logic        accept;
  logic        acs_done;
  logic        last_step;

  function automatic logic length_ok(input logic [7:0] len);
    return (len != 8'd0) && ({1'b0, len} <= MAX_LEN_9);
  endfunction

  assign start_req = (state == S_IDLE) && Start;
  assign accept    = (state == S_COLLECT) && InValid;
  // The AcsStart cycle itself never counts as completion.
  assign acs_done  = (state == S_ACS) && !first_r && AcsDone;
  assign last_step = ((step_r + 8'd1) == len_r);

`ifdef VITERBI_ZERO_TAIL_EN
  logic unused_cost;
  assign unused_cost = ^{CostData, LAST_IDX};
  assign CostAddr    = 6'd0;
`else
  logic [5:0]        scan_idx_r;
  logic [5:0]        min_idx_r;
  logic [COST_W-1:0] min_cost_r;
  logic              cost_less;
  logic              scan_last;
  logic [5:0]        best_idx;

  // Address 0 is already on the bus in the final ACS cycle, so CostData always
  // carries the entry for scan_idx_r and the address runs one ahead.
  assign CostAddr  = (state == S_SCAN) ? scan_idx_r + 6'd1 : 6'd0;
  assign cost_less = (CostData < min_cost_r);
  assign scan_last = (state == S_SCAN) && (scan_idx_r == LAST_IDX);
  assign best_idx  = cost_less ? scan_idx_r : min_idx_r;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      scan_idx_r <= 6'd0;
      min_idx_r  <= 6'd0;
      min_cost_r <= '1;
    end else if (acs_done) begin
      scan_idx_r <= 6'd0;
      min_idx_r  <= 6'd0;
      min_cost_r <= '1;
    end else if (state == S_SCAN) begin
      scan_idx_r <= scan_idx_r + 6'd1;
      if (cost_less) begin
        min_cost_r <= CostData;
        min_idx_r  <= scan_idx_r;
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start_req && length_ok(Length)) state_n = S_INIT;
      S_INIT:    state_n = S_COLLECT;
      S_COLLECT: if (accept && half_r) state_n = S_ACS;
      S_ACS: begin
        if (acs_done) begin
`ifdef VITERBI_ZERO_TAIL_EN
          state_n = last_step ? S_TB : S_COLLECT;
`else
          state_n = last_step ? S_SCAN : S_COLLECT;
`endif
        end
      end
`ifndef VITERBI_ZERO_TAIL_EN
      S_SCAN:    if (scan_last) state_n = S_TB;
`endif
      S_TB:      if (TbDone) state_n = S_FIN;
      S_FIN:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      first_r    <= 1'b0;
      half_r     <= 1'b0;
      len_r      <= 8'd0;
      step_r     <= 8'd0;
      pair_r     <= 2'b00;
      tb_state_r <= 6'd0;
      tb_len_r   <= 8'd0;
      error_r    <= 1'b0;
    end else begin
      state   <= state_n;
      first_r <= (state_n != state);
      error_r <= start_req && !length_ok(Length);
      if (start_req) len_r <= Length;
      if (state == S_INIT) begin
        step_r     <= 8'd0;
        half_r     <= 1'b0;
        tb_state_r <= 6'd0;
        tb_len_r   <= 8'd0;
      end
      if (accept) begin
        half_r <= ~half_r;
        if (!half_r) pair_r[1] <= Input;
        else         pair_r[0] <= Input;
      end
      if (acs_done) step_r <= step_r + 8'd1;
      if ((state_n == S_TB) && (state != S_TB)) tb_len_r <= len_r;
`ifndef VITERBI_ZERO_TAIL_EN
      if (scan_last) tb_state_r <= best_idx;
`endif
    end
  end

  assign InReady  = (state == S_COLLECT);
  assign Clear    = (state == S_INIT);
  assign AcsStart = (state == S_ACS) && first_r;
  assign TbStart  = (state == S_TB) && first_r;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_FIN);
  assign Error    = error_r;
  assign Pair     = pair_r;
  assign Step     = step_r;
  assign TbState  = tb_state_r;
  assign TbLength = tb_len_r;

endmodule

// File: tb/tb_viterbi_frame_controller.sv
// Scoreboard bench for viterbi_frame_controller: random bit streams, handshake timing and cost tables
// against a frame-level reference model.
module tb_viterbi_frame_controller;

`ifdef VITERBI_ZERO_TAIL_EN
  localparam int TB_LAT = 1;
`else
  localparam int TB_LAT = 65;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Length = 8'd0;
  logic       InValid = 1'b0;
  logic       Input = 1'b0;
  logic       InReady, Clear, AcsStart, TbStart, Busy, Done, Error;
  logic [1:0] Pair;
  logic       AcsDone = 1'b0;
  logic [7:0] Step, TbLength;
  logic [5:0] CostAddr, TbState;
  logic [7:0] CostData = 8'd0;
  logic       TbDone = 1'b0;

  viterbi_frame_controller dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Length(Length),
    .InValid(InValid), .Input(Input), .InReady(InReady), .Clear(Clear),
    .AcsStart(AcsStart), .Pair(Pair), .AcsDone(AcsDone), .Step(Step),
    .CostAddr(CostAddr), .CostData(CostData), .TbStart(TbStart),
    .TbState(TbState), .TbLength(TbLength), .TbDone(TbDone),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [1:0] pair; logic [7:0] step; } acs_exp_t;
  typedef struct { logic [5:0] st; logic [7:0] len; } tb_exp_t;

  int       cyc = 0;
  int       checks = 0;
  int       passes = 0;
  int       frames_done = 0;
  int       last_done = 0;
  int       tbdone_cyc = 0;
  int       in_mode = 0;
  int       acs_mode = 0;
  bit       in_acs = 0;
  bit       bit_q[$];
  bit       fixed_bits[$];
  acs_exp_t acs_q[$];
  tb_exp_t  tb_q[$];
  int       clear_q[$];
  int       err_q[$];
  logic [7:0] cost_mem [64];

  always @(posedge Clock) cyc <= cyc + 1;
  always @(posedge Clock) CostData <= cost_mem[CostAddr];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Coded-bit source
  logic acc;
  bit   tog = 0;
  bit   v;
  always begin
    @(negedge Clock);
    acc = InValid && InReady && !Reset;
    @(posedge Clock);
    #1;
    if (acc && bit_q.size() > 0) void'(bit_q.pop_front());
    tog = ~tog;
    case (in_mode)
      0:       v = 1'b1;
      1:       v = tog;
      default: v = 1'($urandom_range(0, 1));
    endcase
    if (bit_q.size() == 0) v = 1'b0;
    InValid = v;
    Input   = v ? bit_q[0] : 1'($urandom_range(0, 1));
  end

  // ACS datapath responder, optionally raising a premature AcsDone in the AcsStart cycle
  int acs_d;
  bit acs_sp;
  always begin
    @(posedge Clock);
    #1;
    if (AcsStart && !Reset) begin
      case (acs_mode)
        0:       begin acs_d = 1; acs_sp = 1'b0; end
        1:       begin acs_d = 5; acs_sp = 1'b1; end
        default: begin acs_d = $urandom_range(2, 6); acs_sp = 1'($urandom_range(0, 1)); end
      endcase
      AcsDone = acs_sp;
      @(posedge Clock);
      #1;
      AcsDone = 1'b0;
      repeat (acs_d - 1) begin @(posedge Clock); #1; end
      AcsDone = 1'b1;
      @(posedge Clock);
      #1;
      AcsDone = 1'b0;
    end
  end

  // Traceback responder
  always begin
    @(posedge Clock);
    #1;
    if (TbStart && !Reset) begin
      repeat ($urandom_range(0, 3)) begin @(posedge Clock); #1; end
      @(posedge Clock);
      #1;
      TbDone = 1'b1;
      tbdone_cyc = cyc;
      @(posedge Clock);
      #1;
      TbDone = 1'b0;
    end
  end

  // Monitor
  acs_exp_t mon_e;
  tb_exp_t  mon_t;
  always @(negedge Clock) begin
    if (Reset) in_acs = 1'b0;
    else begin
      if (Clear) begin
        if (clear_q.size() == 0) chk("unexpected_clear", 32'(Clear), 0);
        else chk("clear_cycle", cyc, clear_q.pop_front());
        chk("busy_in_init", 32'(Busy), 1);
      end
      if (Error) begin
        if (err_q.size() == 0) chk("unexpected_error", 32'(Error), 0);
        else chk("error_cycle", cyc, err_q.pop_front());
      end
      if (AcsStart) begin
        if (acs_q.size() == 0) chk("unexpected_acs", 32'(AcsStart), 0);
        else begin
          mon_e = acs_q.pop_front();
          chk("pair", 32'(Pair), 32'(mon_e.pair));
          chk("step", 32'(Step), 32'(mon_e.step));
        end
        in_acs = 1'b1;
      end
      if (in_acs) begin
        chk("inready_in_acs", 32'(InReady), 0);
        if (AcsDone && !AcsStart) begin
          in_acs = 1'b0;
          last_done = cyc;
        end
      end
      if (TbStart) begin
        if (tb_q.size() == 0) chk("unexpected_tbstart", 32'(TbStart), 0);
        else begin
          mon_t = tb_q.pop_front();
          chk("tb_state", 32'(TbState), 32'(mon_t.st));
          chk("tb_length", 32'(TbLength), 32'(mon_t.len));
          chk("tb_latency", cyc - last_done, TB_LAT);
        end
      end
      if (Done) begin
        chk("done_cycle", cyc, tbdone_cyc + 1);
        frames_done++;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    chk({name, "_ctrl"}, {25'd0, InReady, Clear, AcsStart, TbStart, Busy, Done, Error}, 0);
    chk({name, "_data"}, {2'd0, Pair, Step, CostAddr, TbState, TbLength}, 0);
  endtask

  task automatic err_frame(input int len);
    @(posedge Clock);
    #1;
    Start = 1'b1;
    Length = 8'(len);
    err_q.push_back(cyc + 1);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    @(negedge Clock);
    chk("err_busy", 32'(Busy), 0);
    @(negedge Clock);
    chk("err_pending", err_q.size(), 0);
  endtask

  task automatic run_frame(input int len, input int mode, input int pat, input bit abort);
    int target, n, best;
    bit b1, b0;
    in_mode  = mode;
    acs_mode = mode;
    for (int i = 0; i < 64; i++) begin
      case (pat)
        0:       cost_mem[i] = 8'($urandom_range(0, 255));
        1:       cost_mem[i] = (i == 17 || i == 40) ? 8'h03 : 8'hFF;
        2:       cost_mem[i] = 8'hFF;
        default: cost_mem[i] = 8'($urandom_range(0, 3));
      endcase
    end
    best = 0;
    for (int i = 1; i < 64; i++) if (cost_mem[i] < cost_mem[best]) best = i;
`ifdef VITERBI_ZERO_TAIL_EN
    best = 0;
`endif
    for (int i = 0; i < len; i++) begin
      if (fixed_bits.size() >= 2) begin
        b1 = fixed_bits.pop_front();
        b0 = fixed_bits.pop_front();
      end else begin
        b1 = 1'($urandom_range(0, 1));
        b0 = 1'($urandom_range(0, 1));
      end
      bit_q.push_back(b1);
      bit_q.push_back(b0);
      acs_q.push_back('{pair: {b1, b0}, step: 8'(i)});
    end
    tb_q.push_back('{st: 6'(best), len: 8'(len)});
    target = frames_done + 1;
    @(posedge Clock);
    #1;
    Start = 1'b1;
    Length = 8'(len);
    clear_q.push_back(cyc + 1);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Length = 8'($urandom_range(0, 255));
    // A start request while busy must be ignored (no Error, no Clear).
    repeat (2) @(posedge Clock);
    #1;
    Start = 1'b1;
    Length = 8'd0;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    if (abort) begin
      n = 0;
      do begin @(negedge Clock); n++; end while (!(Step == 8'd5 && InReady) && n < 500);
      chk("reach_step5", 32'(Step), 5);
      #2;
      Reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      bit_q.delete();
      acs_q.delete();
      tb_q.delete();
      clear_q.delete();
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check_reset_outputs("held_reset");
      @(posedge Clock);
      #1;
      Reset = 1'b0;
    end else begin
      n = 0;
      while (frames_done < target && n < len * 24 + 400) begin @(posedge Clock); n++; end
      chk("frame_done", frames_done, target);
      @(negedge Clock);
      chk("busy_after", 32'(Busy), 0);
      chk("bits_left", bit_q.size(), 0);
      chk("pairs_left", acs_q.size(), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) cost_mem[i] = 8'hFF;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_reset_outputs("por");
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    err_frame(0);
    err_frame(193);
    err_frame(255);

    fixed_bits = {1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(2, 0, 1, 1'b0);
    run_frame(5, 1, 1, 1'b0);
    run_frame(4, 0, 2, 1'b0);
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(1, 12), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    run_frame(1, 2, 0, 1'b0);
    run_frame(192, 0, 0, 1'b0);
    err_frame(193);

    run_frame(10, 0, 0, 1'b1);
    run_frame(3, 1, 3, 1'b0);
    run_frame(6, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_controller.md
# viterbi_frame_controller

Frame-level sequencer for the 64-state Viterbi decoder in the receive chain. Accepts the serial coded bit stream, packs bit pairs, and issues one add-compare-select (ACS) step per pair. After the programmed number of trellis steps it selects the traceback start state and launches traceback. It owns cost/path initialisation, step counting, and frame completion/error signalling, so the decoder datapath runs purely on strobes.

## Interface
- `MAX_LENGTH`, 192, maximum trellis steps per frame.
- `STATES`, 64, trellis states; state index width is 6.
- `COST_W`, 8, path-metric width.

Ports:
- `Clock` in 1: single clock; all logic on its rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Start` in 1: frame start request, sampled only in IDLE.
- `Length` in 8: trellis steps for the frame, sampled with `Start`.
- `InValid` in 1: `Input` carries a coded bit.
- `Input` in 1: coded bit.
- `InReady` out 1: controller accepts a coded bit this cycle.
- `Clear` out 1: one-cycle pulse; datapath initialises costs and paths.
- `AcsStart` out 1: one-cycle pulse; `Pair` is valid for this ACS step.
- `Pair` out 2: {first bit, second bit} of the current pair.
- `AcsDone` in 1: datapath finished the current ACS step.
- `Step` out 8: index of the current trellis step.
- `CostAddr` out 6: cost-memory read address used during SCAN.
- `CostData` in COST_W: cost read data, valid one cycle after `CostAddr`.
- `TbStart` out 1: one-cycle pulse that launches traceback.
- `TbState` out 6: traceback start state.
- `TbLength` out 8: traceback length.
- `TbDone` in 1: traceback finished.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse marking frame completion.
- `Error` out 1: one-cycle pulse marking a rejected frame.

## Operation
- States: IDLE, INIT, COLLECT, ACS, SCAN, TB, FIN.
- IDLE: when `Start` is high, latch `Length`.
  - `Length` of 0 or greater than `MAX_LENGTH`: pulse `Error`, stay in IDLE.
  - Otherwise go to INIT.
  - `Start` is ignored in every other state.
- INIT: `Clear`=1 for one cycle; `Step`=0; go to COLLECT.
- COLLECT: `InReady`=1. A bit is accepted when `InValid & InReady`.
  - First accepted bit goes to `Pair[1]`; second goes to `Pair[0]`.
  - The second bit moves the FSM to ACS.
- ACS: `AcsStart` pulses and `Pair` is held, both on the first ACS cycle only. `InReady`=0.
  - `AcsDone` sampled in the `AcsStart` cycle is ignored.
  - On `AcsDone`: `Step`++. If new `Step`==`Length`, go to SCAN (or TB, see Configuration); else go to COLLECT.
- SCAN: `CostAddr` sweeps 0..63, one address per cycle.
  - Track the minimum `CostData` and its index.
  - Compare is strictly less-than, so ties resolve to the lowest index.
  - The minimum register starts at all-ones; index starts at 0.
  - After the 64th datum, `TbState`=argmin; go to TB.
- TB: `TbStart` pulses on the first TB cycle; `TbLength`=`Length`; wait for `TbDone`, then go to FIN.
- FIN: `Done`=1 for one cycle; go to IDLE.
- Reset in any state: FSM returns to IDLE immediately; partial frame discarded; no `Done` or `Error` pulse.
- Reset values: every output 0, `Pair`=00, `TbState`=0, `CostAddr`=0, `Step`=0, `TbLength`=0.

## Timing
- `Start` at cycle t: `Clear` at t+1; `InReady` from t+2.
- Second bit of a pair accepted at cycle c: `AcsStart` at c+1. Earliest `AcsDone` is c+2. `InReady` returns the cycle after `AcsDone`.
- Minimum cycles per step: 2 collect + 2 ACS = 4.
- SCAN latency: 65 cycles (64 addresses plus 1 read latency). `TbStart` follows on the next cycle.
- `Done` comes one cycle after `TbDone`.
- `Step` updates the cycle after `AcsDone`. `TbState` and `TbLength` hold until the next `Clear`.

## Configuration
- `VITERBI_ZERO_TAIL_EN` defined: SCAN is removed. Last `AcsDone` leads directly to TB with `TbState`=0, since the frame is zero-tail terminated. `CostAddr` stays 0 and `CostData` is unused.
- Undefined: full SCAN best-state search as described above.

## Test plan
- `Length`=0 or 193 with `Start` -> `Error` pulse one cycle later, `Busy` stays 0, no `Clear`.
- `Length`=2, bits 1,0,1,1 with `InValid` continuous and `AcsDone` 1 cycle after each `AcsStart` -> `Pair`=10 then 11; `Step` goes 0→1→2; `TbLength`=2; single `Done`.
- `InValid` toggled every other cycle, `AcsDone` delayed 5 cycles -> no bit dropped or duplicated; `InReady`=0 throughout ACS; `AcsDone` asserted in the `AcsStart` cycle is ignored.
- SCAN (macro undefined): costs all 0xFF except index 17=0x03 and index 40=0x03 -> `TbState`=17; `TbStart` exactly 65 cycles after the last `AcsDone`.
- Macro defined -> `TbStart` the cycle after the last `AcsDone`, `TbState`=0.
- `Reset` asserted mid-COLLECT at `Step`=5, then a new `Start` -> all outputs return to reset values; new frame starts at `Step`=0 with a fresh `Clear`.
